// File: rtl/gpio_reg_bank.sv
// GPIO-driven configuration register bank: synchronises the host write strobe,
// assembles multi-byte registers MSB-first and offers registered readback.

module gpio_reg_slot #(
  parameter int REG_W = 32,
  parameter bit PULSE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit,
  input  logic [REG_W-1:0] wdata,
  output logic [REG_W-1:0] q,
  output logic             strobe
);
  logic [REG_W-1:0] val_d, val_q;
  logic             stb_d, stb_q;

  // Trigger-style registers hold a committed value for a single cycle only.
  always_comb begin
    val_d = val_q;
    stb_d = commit;
    if (commit)     val_d = wdata;
    else if (PULSE) val_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_q <= '0;
      stb_q <= 1'b0;
    end else begin
      val_q <= val_d;
      stb_q <= stb_d;
    end
  end

  assign q      = val_q;
  assign strobe = stb_q;
endmodule

module gpio_reg_bank #(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 8,
  parameter int                NUM_REGS    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'h0000,
  parameter int                REG_W       = 32,
  parameter logic [NUM_REGS-1:0] PULSE_MASK = '0,
  parameter int                SYNC_STAGES = 2,
  localparam int BYTES  = REG_W / DATA_W,
  localparam int CNT_W  = $clog2(BYTES + 1),
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int GPIO_W = ADDR_W + DATA_W + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [GPIO_W-1:0]         gpio_in,
  output logic [NUM_REGS*REG_W-1:0] reg_out,
  output logic [NUM_REGS-1:0]       wr_strobe,
  output logic [REG_W-1:0]          rd_data,
  output logic [CNT_W-1:0]          byte_cnt
);
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } wr_req_t;

  wr_req_t wr;
  assign wr = wr_req_t'(gpio_in[GPIO_W-2:0]);

  // ---------------- w_clk synchroniser and rise detect ----------------
  logic [SYNC_STAGES-1:0] sync_d, sync_q;
  logic [SYNC_STAGES-1:0] vld_pipe_d, vld_pipe_q;
  logic                   prev_d, prev_q;
  logic                   armed_d, armed_q;
  logic                   w_lvl, sync_vld, rise;

  assign w_lvl    = sync_q[SYNC_STAGES-1];
  assign sync_vld = vld_pipe_q[SYNC_STAGES-1];

  // Chain contents are only trusted once refilled after reset, and a write
  // needs a genuine low first so a level held across reset is not a rise.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], gpio_in[GPIO_W-1]};
    vld_pipe_d = {vld_pipe_q[SYNC_STAGES-2:0], 1'b1};
    prev_d     = w_lvl;
    armed_d    = armed_q | (sync_vld & ~w_lvl);
  end

  assign rise = armed_q & sync_vld & w_lvl & ~prev_q;

  // ---------------- address decode ----------------
  logic [ADDR_W:0]    off;
  logic               in_range;
  logic [IDX_W-1:0]   idx;

  assign off      = {1'b0, wr.addr} - {1'b0, BASE_ADDR};
  assign in_range = ~off[ADDR_W] && (off < (ADDR_W+1)'(NUM_REGS));
  assign idx      = off[IDX_W-1:0];

  // ---------------- byte assembly ----------------
  logic [REG_W-1:0]    shadow_d, shadow_q;
  logic [ADDR_W-1:0]   pend_d, pend_q;
  logic [CNT_W-1:0]    cnt_d, cnt_q;
  logic [IDX_W-1:0]    ptr_d, ptr_q;
  logic [REG_W-1:0]    nxt_shadow;
  logic [CNT_W-1:0]    nxt_cnt;
  logic [NUM_REGS-1:0] commit;

  always_comb begin
    shadow_d   = shadow_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    commit     = '0;
    nxt_shadow = shadow_q;
    nxt_cnt    = cnt_q;
    if (rise) begin
      if (in_range) begin
        ptr_d  = idx;
        pend_d = wr.addr;
        if (wr.addr != pend_q || cnt_q == '0) begin
          nxt_shadow = REG_W'(wr.data);
          nxt_cnt    = CNT_W'(1);
        end else begin
          nxt_shadow = (shadow_q << DATA_W) | REG_W'(wr.data);
          nxt_cnt    = cnt_q + CNT_W'(1);
        end
        shadow_d = nxt_shadow;
        if (nxt_cnt == CNT_W'(BYTES)) begin
          cnt_d       = '0;
          commit[idx] = 1'b1;
        end else begin
          cnt_d = nxt_cnt;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  // ---------------- register slots ----------------
  logic [NUM_REGS-1:0][REG_W-1:0] regs;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_slot
    gpio_reg_slot #(
      .REG_W (REG_W),
      .PULSE (PULSE_MASK[g])
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .commit (commit[g]),
      .wdata  (shadow_d),
      .q      (regs[g]),
      .strobe (wr_strobe[g])
    );
  end

  logic [REG_W-1:0] rd_d, rd_q;
  assign rd_d = regs[ptr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= '0;
      vld_pipe_q <= '0;
      prev_q     <= 1'b0;
      armed_q    <= 1'b0;
      shadow_q   <= '0;
      pend_q     <= '0;
      cnt_q      <= '0;
      ptr_q      <= '0;
      rd_q       <= '0;
    end else begin
      sync_q     <= sync_d;
      vld_pipe_q <= vld_pipe_d;
      prev_q     <= prev_d;
      armed_q    <= armed_d;
      shadow_q   <= shadow_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      rd_q       <= rd_d;
    end
  end

  assign reg_out  = regs;
  assign rd_data  = rd_q;
  assign byte_cnt = cnt_q;
endmodule

// File: tb/tb_gpio_reg_bank.sv
// Scoreboard bench for gpio_reg_bank: a byte-list reference model predicts
// commits; a monitor pops them whenever a write strobe appears.
module tb_gpio_reg_bank;
  localparam int AW = 16, DW = 8, NR = 16, RW = 32, BYTES = 4;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [AW+DW:0] gpio_a = '0, gpio_b = '0;

  logic [NR*RW-1:0] reg_out_a;
  logic [NR-1:0]    stb_a;
  logic [RW-1:0]    rd_a;
  logic [2:0]       cnt_a;

  logic [NB*8-1:0]  reg_out_b;
  logic [NB-1:0]    stb_b;
  logic [7:0]       rd_b;
  logic             cnt_b;

  int errors = 0, checks = 0;
  int cyc = 0;

  gpio_reg_bank #(.PULSE_MASK(16'h0001)) dut_a (
    .clk(clk), .rst(rst_n), .gpio_in(gpio_a),
    .reg_out(reg_out_a), .wr_strobe(stb_a), .rd_data(rd_a), .byte_cnt(cnt_a)
  );

  gpio_reg_bank #(.NUM_REGS(NB), .BASE_ADDR(16'h0015), .REG_W(8)) dut_b (
    .clk(clk), .rst(rst_n), .gpio_in(gpio_b),
    .reg_out(reg_out_b), .wr_strobe(stb_b), .rd_data(rd_b), .byte_cnt(cnt_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int           idx;
    logic [RW-1:0] val;
    int           cyc;
  } exp_t;

  exp_t          sb[$];
  logic [RW-1:0] m_mem [NR];
  logic [7:0]    m_bytes[$];
  logic [AW-1:0] m_pend;
  int            m_ptr;
  logic [NR-1:0] pmask_v = 16'h0001;

  function automatic void m_reset();
    for (int i = 0; i < NR; i++) m_mem[i] = '0;
    m_bytes.delete();
    m_pend = '0;
    m_ptr  = 0;
  endfunction

  function automatic void model_write(input logic [AW-1:0] addr, input logic [7:0] data,
                                      input int drive_cyc);
    int off;
    logic [RW-1:0] v;
    off = int'(addr);
    if (off < NR) begin
      if (addr != m_pend || m_bytes.size() == 0) m_bytes.delete();
      m_bytes.push_back(data);
      m_pend = addr;
      m_ptr  = off;
      if (m_bytes.size() == BYTES) begin
        v = '0;
        foreach (m_bytes[j]) v = (v << 8) | RW'(m_bytes[j]);
        // w_clk first sampled one edge after the drive, commit two edges later
        sb.push_back('{off, v, drive_cyc + 3});
        m_mem[off] = pmask_v[off] ? '0 : v;
        m_bytes.delete();
      end
    end else begin
      m_bytes.delete();
    end
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_byte_cnt"}, 64'(cnt_a), 64'(m_bytes.size()));
    chk({tag, "_rd_data"}, 64'(rd_a), 64'(m_mem[m_ptr]));
    for (int i = 0; i < NR; i++)
      chk($sformatf("%s_reg%0d", tag, i), 64'(reg_out_a[i*RW +: RW]), 64'(m_mem[i]));
  endtask

  task automatic wr_a(input logic [AW-1:0] addr, input logic [7:0] data,
                      input int hi = 4, input int lo = 4);
    @(negedge clk);
    gpio_a = {1'b0, data, addr};
    @(negedge clk);
    gpio_a[AW+DW] = 1'b1;
    model_write(addr, data, cyc);
    repeat (hi) @(negedge clk);
    gpio_a[AW+DW] = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  exp_t          e_cur;
  logic          pend_chk = 1'b0;
  int            pend_idx = 0;
  logic [RW-1:0] pend_rd = '0;

  always @(negedge clk) begin
    if (pend_chk) begin
      chk("strobe_one_cycle", 64'(stb_a[pend_idx]), 64'd0);
      chk("rd_after_commit", 64'(rd_a), 64'(pend_rd));
      if (pmask_v[pend_idx])
        chk("pulse_cleared", 64'(reg_out_a[pend_idx*RW +: RW]), 64'd0);
      pend_chk = 1'b0;
    end
    if (stb_a != '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got %0h expected 0 (cycle %0d)", stb_a, cyc);
      end else begin
        e_cur = sb.pop_front();
        chk("strobe_idx", 64'(stb_a), 64'(32'd1 << e_cur.idx));
        chk("commit_val", 64'(reg_out_a[e_cur.idx*RW +: RW]), 64'(e_cur.val));
        chk("commit_cycle", 64'(cyc), 64'(e_cur.cyc));
        pend_chk = 1'b1;
        pend_idx = e_cur.idx;
        pend_rd  = e_cur.val;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    logic [AW-1:0] last_addr;
    logic [AW-1:0] a;
    logic [7:0] d;
    logic [7:0] bytes_e[4];

    m_reset();
    repeat (3) @(negedge clk);
    chk("reset_byte_cnt", 64'(cnt_a), 64'd0);
    chk("reset_rd_data", 64'(rd_a), 64'd0);
    chk("reset_strobe", 64'(stb_a), 64'd0);
    chk("reset_regs_nonzero", 64'(reg_out_a != '0), 64'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // byte assembly
    wr_a(16'h000C, 8'h11); check_state("asm1");
    wr_a(16'h000C, 8'h22); check_state("asm2");
    wr_a(16'h000C, 8'h33); check_state("asm3");
    wr_a(16'h000C, 8'h44); check_state("asm4");
    chk("asm_reg12", 64'(reg_out_a[12*RW +: RW]), 64'h11223344);

    // interrupted assembly
    wr_a(16'h000D, 8'h01);
    wr_a(16'h000D, 8'h02); check_state("intr_partial");
    bytes_e = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    foreach (bytes_e[j]) wr_a(16'h000E, bytes_e[j]);
    check_state("intr_done");
    chk("intr_reg14", 64'(reg_out_a[14*RW +: RW]), 64'hAABBCCDD);

    // self-clearing register 0
    bytes_e = '{8'h00, 8'h00, 8'h00, 8'h01};
    foreach (bytes_e[j]) wr_a(16'h0000, bytes_e[j]);
    check_state("pulse");

    // out of range drops a partial assembly
    wr_a(16'h0003, 8'h5C); check_state("oor_pre");
    wr_a(16'h0010, 8'hEE); check_state("oor");

    // long high phase gives exactly one write
    wr_a(16'h0007, 8'h99, 20, 4); check_state("long_hi");

    // reset while w_clk is high
    @(negedge clk);
    gpio_a = {1'b0, 8'h77, 16'h0005};
    @(negedge clk);
    gpio_a[AW+DW] = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    check_state("mid_reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_state("after_release");
    gpio_a[AW+DW] = 1'b0;
    repeat (4) @(negedge clk);
    gpio_a[AW+DW] = 1'b1;
    model_write(16'h0005, 8'h77, cyc);
    repeat (4) @(negedge clk);
    gpio_a[AW+DW] = 1'b0;
    repeat (4) @(negedge clk);
    check_state("rewrite");

    // randomized traffic, biased toward repeated addresses so commits happen
    last_addr = 16'h0009;
    for (int n = 0; n < 80; n++) begin
      a = ($urandom_range(0, 99) < 75) ? last_addr : AW'($urandom_range(0, 19));
      d = 8'($urandom());
      wr_a(a, d);
      check_state($sformatf("rnd%0d", n));
      last_addr = a;
    end

    // narrow-register instance: single write commits
    @(negedge clk);
    gpio_b = {1'b0, 8'h5A, 16'h0016};
    @(negedge clk);
    gpio_b[AW+DW] = 1'b1;
    k = cyc;
    while (cyc < k + 2) @(negedge clk);
    chk("b_before_commit", 64'(reg_out_b), 64'd0);
    @(negedge clk);
    chk("b_strobe", 64'(stb_b), 64'b0010);
    chk("b_reg1", 64'(reg_out_b[15:8]), 64'h5A);
    chk("b_byte_cnt", 64'(cnt_b), 64'd0);
    chk("b_rd_not_yet", 64'(rd_b), 64'd0);
    @(negedge clk);
    chk("b_rd_data", 64'(rd_b), 64'h5A);
    chk("b_strobe_off", 64'(stb_b), 64'd0);
    repeat (2) @(negedge clk);
    gpio_b[AW+DW] = 1'b0;
    repeat (4) @(negedge clk);
    gpio_b = {1'b0, 8'h33, 16'h0014};
    @(negedge clk);
    gpio_b[AW+DW] = 1'b1;
    repeat (4) @(negedge clk);
    gpio_b[AW+DW] = 1'b0;
    repeat (4) @(negedge clk);
    chk("b_oor_regs", 64'(reg_out_b), 64'h0000_5A00);
    chk("b_oor_rd", 64'(rd_b), 64'h5A);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gpio_reg_bank.md
# gpio_reg_bank

Parametrised GPIO-driven configuration register bank that turns the host's 25-bit GPIO word (`w_clk`, data byte, address) into a set of multi-byte control registers for the Ising machine datapath. It synchronises the host write strobe, assembles `REG_W`-bit registers from successive `DATA_W`-bit writes, and marks selected registers as self-clearing triggers (run, delay-trigger, halt style). It provides readback of the last-addressed register. It sits between the PS GPIO and every PL block that consumes configuration: scalers, drivers, DAC muxes and shift amounts.

## Interface
- `ADDR_W`, 16, address field width; GPIO bits `[ADDR_W-1:0]`.
- `DATA_W`, 8, data field width; GPIO bits `[ADDR_W+DATA_W-1:ADDR_W]`.
- `NUM_REGS`, 16, number of registers.
- `BASE_ADDR`, 16'h0000, address of register 0; register i is at `BASE_ADDR+i`.
- `REG_W`, 32, register width; must be an integer multiple of `DATA_W`; `BYTES = REG_W/DATA_W`.
- `PULSE_MASK`, 0, `NUM_REGS`-bit mask; bit i=1 makes register i self-clearing.
- `SYNC_STAGES`, 2, synchroniser depth for `w_clk` (≥2).
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `gpio_in`  in  `ADDR_W+DATA_W+1`  host word; the MSB (bit 24 at defaults) is `w_clk`.
- `reg_out`  out  `NUM_REGS*REG_W`  register contents; register i occupies `[i*REG_W +: REG_W]`.
- `wr_strobe`  out  `NUM_REGS`  one-cycle pulse on commit of register i.
- `rd_data`  out  `REG_W`  committed value of the last in-range addressed register.
- `byte_cnt`  out  `$clog2(BYTES+1)`  bytes held in the partial assembly.

## Operation
- `w_clk` passes through a `SYNC_STAGES` flop chain. A rise is detected as last stage = 1 and previous-cycle last stage = 0. Falls are ignored.
- Address and data are sampled from `gpio_in` on the cycle the rise is detected. The host holds them stable from raising `w_clk` until it lowers it.
- Write to an in-range address `A` (`BASE_ADDR ≤ A < BASE_ADDR+NUM_REGS`), with index `i = A-BASE_ADDR`:
  - If `A` differs from the pending address, or `byte_cnt == 0`: the partial assembly is discarded, the pending address becomes `A`, `shadow = data`, and `byte_cnt = 1`.
  - Otherwise: `shadow = {shadow[REG_W-DATA_W-1:0], data}` (MSB byte first) and `byte_cnt` increments.
  - When `byte_cnt` would reach `BYTES`: commit the full shadow word to register i, pulse `wr_strobe[i]`, and set `byte_cnt` to 0.
  - With `BYTES == 1`, every write commits.
- Every in-range write, including partial ones, updates the readback pointer to i.
- Out-of-range write: discards the partial assembly, sets `byte_cnt` to 0, and changes no register, strobe or readback pointer.
- Self-clearing register (`PULSE_MASK[i] = 1`): it holds the committed value for exactly one cycle, then returns to 0 on the next edge.
- `rd_data` is registered and equals `reg_out[ptr]`. It is 0 until the first in-range write.

## Timing
- Reset values: `reg_out`, `wr_strobe`, `rd_data`, `byte_cnt`, shadow, pending address, readback pointer and synchroniser are all 0.
- Reset asserted mid-assembly or mid-synchronisation clears everything. A `w_clk` level that is still high after reset releases is treated as already seen; no write occurs until it falls and rises again.
- Let `w_clk` first be sampled high at edge N. Commit, `wr_strobe` and `byte_cnt` update at edge N+`SYNC_STAGES`.
- `rd_data` reflects the new value at edge N+`SYNC_STAGES`+1.
- Self-clearing register: nonzero only between edges N+`SYNC_STAGES` and N+`SYNC_STAGES`+1.
- `wr_strobe` is high for exactly one cycle per commit. The minimum host write period is 2·`SYNC_STAGES`+2 clk cycles (high and low phases each ≥ `SYNC_STAGES`+1).
- `w_clk` pulses shorter than one clk period may be missed; this is host responsibility and no error is flagged.

## Test plan
- **Byte assembly:** defaults, four writes to 16'h000C with data 11,22,33,44 → `reg_out[12]` = 32'h11223344 at edge N+2 of the fourth write; `wr_strobe[12]` high for one cycle; `byte_cnt` sequence 1,2,3,0.
- **Interrupted assembly:** two bytes to 16'h000D, then four bytes AA,BB,CC,DD to 16'h000E → reg 13 unchanged (0); reg 14 = 32'hAABBCCDD; no strobe for 13.
- **Self-clearing register:** `PULSE_MASK` bit 0 set, four writes 00,00,00,01 to 16'h0000 → `reg_out[0]` = 1 for exactly one cycle, then 0; `wr_strobe[0]` coincident.
- **Out-of-range write:** write to 16'h0010 with `NUM_REGS` = 16 → no register change, `byte_cnt` = 0, `rd_data` unchanged.
- **Edge handling:** hold `w_clk` high 20 cycles → exactly one write. Assert `rst` while `w_clk` is high, release it, then lower and raise `w_clk` → exactly one write after release, none at release.
- **Parametrisation:** with `REG_W` = 8 and `BASE_ADDR` = 16'h0015, a single write of 5A to 16'h0016 → `reg_out[1]` = 8'h5A, and `rd_data` = 8'h5A one cycle after the commit.
